// File: rtl/uart_byte_link_if.sv
// Upstream byte interface of the UART link: write and read 4-phase
// handshakes plus the RX-data-available and TX-space-available levels.
interface uart_byte_link_if;
  logic [7:0] din;
  logic       we;
  logic       wack;
  logic [7:0] dout;
  logic       re;
  logic       rack;
  logic       ra;
  logic       wa;

  modport master (output din, we, re, input wack, dout, rack, ra, wa);
  modport slave  (input din, we, re, output wack, dout, rack, ra, wa);
endinterface

// File: rtl/uart_byte_link.sv
// Byte-level 8N1 UART transceiver with TX/RX FIFOs behind 4-phase handshakes.
//
// state   | TX meaning                     | RX meaning
// IDLE    | line high, pop when data ready | wait for rs low (after rs high if
//         |                                | the last frame had a bad stop bit)
// START   | drive start bit                | wait half a bit, confirm start
// DATA    | drive 8 bits, LSB first        | sample 8 bit centres, LSB first
// STOP    | drive stop bit                 | sample stop bit, push or flag
module uart_byte_link #(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic              tx_out,
  output logic              rx_overrun,
  output logic              frame_err,
  uart_byte_link_if.slave   bus
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(BAUD_DIV);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CW-1:0]    BIT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0] tx_mem_q [DEPTH];
  logic [7:0] rx_mem_q [DEPTH];

  logic [FIFO_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic               wack_q, wack_d, rack_q, rack_d;
  logic [7:0]         dout_q, dout_d;
  state_t             tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0]      tx_baud_q, tx_baud_d, rx_baud_q, rx_baud_d;
  logic [2:0]         tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]         tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic               tx_out_q, tx_out_d;
  logic               rx_s1_q, rx_s1_d, rs_q, rs_d;
  logic               rx_wait_q, rx_wait_d;
  logic               rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d;
  logic               tx_push, tx_pop, rx_push, rx_pop;

  // Upstream handshakes: push/pop only on a fresh request, ack follows the request level
  always_comb begin
    tx_push = bus.we && !wack_q && (tx_cnt_q != FULL_CNT);
    rx_pop  = bus.re && !rack_q && (rx_cnt_q != '0);
    wack_d  = tx_push ? 1'b1 : (bus.we ? wack_q : 1'b0);
    rack_d  = rx_pop  ? 1'b1 : (bus.re ? rack_q : 1'b0);
    dout_d  = rx_pop  ? rx_mem_q[rx_rp_q] : dout_q;
  end

  // TX framer: pops the FIFO head and shifts it out 8N1 with a registered line
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_out_d = 1'b1;
        if (tx_cnt_q != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rp_q];
          tx_baud_d  = '0;
          tx_out_d   = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_out_d   = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = S_DATA;
        end else tx_baud_d = tx_baud_q + 1'b1;
      end
      S_DATA: begin
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_out_d   = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_out_d   = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else tx_baud_d = tx_baud_q + 1'b1;
      end
      default: begin
        if (tx_baud_q == BIT_LAST) tx_state_d = S_IDLE;
        else tx_baud_d = tx_baud_q + 1'b1;
      end
    endcase
  end

  // RX deframer on the synchronised line; a bad stop bit arms a wait for line-high
  always_comb begin
    rx_s1_d      = rx_in;
    rs_d         = rx_s1_q;
    rx_state_d   = rx_state_q;
    rx_baud_d    = rx_baud_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_wait_d    = rx_wait_q;
    rx_overrun_d = rx_overrun_q;
    frame_err_d  = frame_err_q;
    rx_push      = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_wait_q) begin
          if (rs_q) rx_wait_d = 1'b0;
        end else if (!rs_q) begin
          rx_baud_d  = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rs_q ? S_IDLE : S_DATA;
        end else rx_baud_d = rx_baud_q + 1'b1;
      end
      S_DATA: begin
        if (rx_baud_q == BIT_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rs_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 1'b1;
        end else rx_baud_d = rx_baud_q + 1'b1;
      end
      default: begin
        if (rx_baud_q == BIT_LAST) begin
          rx_state_d = S_IDLE;
          if (!rs_q) begin
            frame_err_d = 1'b1;
            rx_wait_d   = 1'b1;
          end else if (rx_cnt_q == FULL_CNT) rx_overrun_d = 1'b1;
          else rx_push = 1'b1;
        end else rx_baud_d = rx_baud_q + 1'b1;
      end
    endcase
  end

  // FIFO pointers and counts; simultaneous push and pop leave the count unchanged
  always_comb begin
    tx_wp_d  = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
  end

  // FIFO storage needs no reset; validity is tracked by the pointers and counts
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= bus.din;
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_shift_q;
  end

  // All control state; reset idles both lines and empties both FIFOs immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
      wack_q <= 1'b0; rack_q <= 1'b0; dout_q <= '0;
      tx_state_q <= S_IDLE; tx_baud_q <= '0; tx_bit_q <= '0;
      tx_shift_q <= '0; tx_out_q <= 1'b1;
      rx_s1_q <= 1'b1; rs_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_baud_q <= '0; rx_bit_q <= '0;
      rx_shift_q <= '0; rx_wait_q <= 1'b0;
      rx_overrun_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; tx_cnt_q <= tx_cnt_d;
      rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d; rx_cnt_q <= rx_cnt_d;
      wack_q <= wack_d; rack_q <= rack_d; dout_q <= dout_d;
      tx_state_q <= tx_state_d; tx_baud_q <= tx_baud_d; tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d; tx_out_q <= tx_out_d;
      rx_s1_q <= rx_s1_d; rs_q <= rs_d;
      rx_state_q <= rx_state_d; rx_baud_q <= rx_baud_d; rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d; rx_wait_q <= rx_wait_d;
      rx_overrun_q <= rx_overrun_d; frame_err_q <= frame_err_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;
  assign bus.wack   = wack_q;
  assign bus.rack   = rack_q;
  assign bus.dout   = dout_q;
  assign bus.ra     = (rx_cnt_q != '0);
  assign bus.wa     = (tx_cnt_q != FULL_CNT);
endmodule
